// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: FSM state encoding, default timing and sizing helpers shared by the SRAM port arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_HOLD   = 2'd3
    } arb_state_e;

    localparam int DEF_N_CH       = 3;
    localparam int DEF_ADDR_WIDTH = 17;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RD_WAIT    = 2;
    localparam int DEF_WR_PULSE   = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The access counter only ever holds (cycles - 1), so clog2 of the longest strobe is enough.
    function automatic int cnt_width(input int rd, input int wr);
        int m;
        m = (rd > wr) ? rd : wr;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: client-side request/grant bundle between the MLP engines (master) and the arbiter (slave).
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [N_CH-1:0]            req;
    logic [N_CH-1:0]            req_we;
    logic [N_CH*ADDR_WIDTH-1:0] req_addr;
    logic [N_CH*DATA_WIDTH-1:0] req_wdata;
    logic [N_CH-1:0]            gnt;
    logic [N_CH-1:0]            done;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       busy;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, done, rdata, busy
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, done, rdata, busy
    );

endinterface

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner selection (one-hot and index).
// SRAM_ARB_RR_EN defined: round-robin search from ptr_i; undefined: fixed priority, lowest index wins.
module sram_arb_pick
    import sram_port_arbiter_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    localparam int PW   = idx_width(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
`ifdef SRAM_ARB_RR_EN
    input  logic [PW-1:0]   ptr_i,
`endif
    output logic            any_o,
    output logic [N_CH-1:0] onehot_o,
    output logic [PW-1:0]   idx_o
);

    logic [PW-1:0] c;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        c     = '0;
        for (int k = 0; k < N_CH; k++) begin
`ifdef SRAM_ARB_RR_EN
            c = PW'((int'(ptr_i) + k) % N_CH);
`else
            c = PW'(k);
`endif
            if (!any_o && req_i[c]) begin
                any_o = 1'b1;
                idx_o = c;
            end
        end
        onehot_o = any_o ? (N_CH'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: arbitrates N_CH clients onto one asynchronous SRAM port, sequencing cs_n/oe_n/we_n itself.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_WAIT    = DEF_RD_WAIT,
    parameter int WR_PULSE   = DEF_WR_PULSE
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_port_arbiter_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data_input,
    output logic [DATA_WIDTH-1:0] sram_data_output,
    output logic                  sram_data_output_en,
    output logic                  sram_cs_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int PW = idx_width(N_CH);
    localparam int CW = cnt_width(RD_WAIT, WR_PULSE);

    arb_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         sel_q, sel_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [N_CH-1:0]       gnt_q, gnt_d;
    logic [N_CH-1:0]       done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  cs_n_q, cs_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  den_q, den_d;
`ifdef SRAM_ARB_RR_EN
    logic [PW-1:0]         ptr_q, ptr_d;
`endif

    logic                  win_any;
    logic [N_CH-1:0]       win_oh;
    logic [PW-1:0]         win_idx;
    logic [ADDR_WIDTH-1:0] addr_a  [N_CH];
    logic [DATA_WIDTH-1:0] wdata_a [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign addr_a[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    sram_arb_pick #(.N_CH(N_CH)) u_pick (
        .req_i    (bus.req),
`ifdef SRAM_ARB_RR_EN
        .ptr_i    (ptr_q),
`endif
        .any_o    (win_any),
        .onehot_o (win_oh),
        .idx_o    (win_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_d   = '0;
        done_d  = '0;
        rdata_d = rdata_q;
        cs_n_d  = cs_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        den_d   = den_q;
`ifdef SRAM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ARB_IDLE: if (win_any) begin
                state_d = ARB_SETUP;
                sel_d   = win_idx;
                we_d    = bus.req_we[win_idx];
                addr_d  = addr_a[win_idx];
                wdata_d = wdata_a[win_idx];
                gnt_d   = win_oh;
                cs_n_d  = 1'b0;
                oe_n_d  = bus.req_we[win_idx];
                den_d   = bus.req_we[win_idx];
`ifdef SRAM_ARB_RR_EN
                ptr_d   = (win_idx == PW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
`endif
            end
            ARB_SETUP: begin
                state_d = ARB_ACCESS;
                cnt_d   = we_q ? CW'(WR_PULSE - 1) : CW'(RD_WAIT - 1);
                we_n_d  = !we_q;
            end
            ARB_ACCESS: if (cnt_q == '0) begin
                state_d = ARB_HOLD;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                done_d  = N_CH'(1) << sel_q;
                rdata_d = we_q ? rdata_q : sram_data_input;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            ARB_HOLD: begin
                state_d = ARB_IDLE;
                cs_n_d  = 1'b1;
                den_d   = 1'b0;
            end
            default: state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    // Reset drops every strobe on the next edge; an in-flight transaction is abandoned without done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            den_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            den_q   <= den_d;
`ifdef SRAM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.done            = done_q;
    assign bus.rdata           = rdata_q;
    assign bus.busy            = busy_q;
    assign sram_addr           = addr_q;
    assign sram_data_output    = wdata_q;
    assign sram_data_output_en = den_q;
    assign sram_cs_n           = cs_n_q;
    assign sram_oe_n           = oe_n_q;
    assign sram_we_n           = we_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: self-checking bench with an asynchronous SRAM model and a cadence/arbitration reference model.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int RD = 2;
    localparam int WR = 2;
    localparam int P  = RD + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rr_ptr = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_port_arbiter_if #(.N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;
    logic          sram_den, sram_cs_n, sram_oe_n, sram_we_n;

    sram_port_arbiter #(
        .N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(RD), .WR_PULSE(WR)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .sram_addr           (sram_addr),
        .sram_data_input     (sram_din),
        .sram_data_output    (sram_dout),
        .sram_data_output_en (sram_den),
        .sram_cs_n           (sram_cs_n),
        .sram_oe_n           (sram_oe_n),
        .sram_we_n           (sram_we_n)
    );

    // Asynchronous SRAM: reads are combinational, writes commit on the rising we_n edge while still selected.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          we_low = 1'b0;
    logic [DW-1:0] ref_mem [int];

    always_comb sram_din = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

    always @(negedge clk) begin
        if (we_low && sram_we_n && !sram_cs_n && sram_den) mem[sram_addr] = sram_dout;
        we_low = !sram_we_n;
    end

    always @(negedge clk) begin
        if (!reset && (bus.gnt != '0 || bus.done != '0)) begin
            checks++;
            if (bus.gnt != '0 && bus.done != '0) begin
                errors++;
                $display("FAIL gnt_done_overlap cyc=%0d gnt=%b done=%b, expected not both nonzero", cyc, bus.gnt, bus.done);
            end
        end
    end

    function automatic int model_pick(input logic [N-1:0] r);
`ifdef SRAM_ARB_RR_EN
        for (int k = 0; k < N; k++) if (r[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return -1;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.req = '0;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic wait_gnt(output int w, output int at);
        w = -1;
        at = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.gnt != '0) begin
                for (int k = N - 1; k >= 0; k--) if (bus.gnt[k]) w = k;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req = '1;
        tick();
        tick();
        checks++;
        if ({bus.gnt, bus.done, bus.rdata, bus.busy, sram_addr, sram_dout, sram_den, sram_cs_n, sram_oe_n, sram_we_n}
            !== {3'b000, 3'b000, 8'h00, 1'b0, 17'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_values gnt=%b done=%b rdata=%h busy=%b addr=%h dout=%h den=%b cs_n=%b oe_n=%b we_n=%b, expected 0/0/0/0/0/0/0/1/1/1",
                     bus.gnt, bus.done, bus.rdata, bus.busy, sram_addr, sram_dout, sram_den, sram_cs_n, sram_oe_n, sram_we_n);
        end
        bus.req = '0;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== '0) begin
            errors++;
            $display("FAIL reset_idle busy=%b gnt=%b, expected 0 and 000", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_read;
        logic [N-1:0] eg, ed;
        logic eo, ec, eb;
        do_reset();
        mem[17'h00123] = 8'hA5;
        bus.req_we[1] = 1'b0;
        bus.req_addr[AW +: AW] = 17'h00123;
        bus.req[1] = 1'b1;
        for (int c = 1; c <= RD + 4; c++) begin
            tick();
            if (c == 1) bus.req[1] = 1'b0;
            eg = (c == 1) ? N'(2) : '0;
            ed = (c == RD + 2) ? N'(2) : '0;
            eo = !(c <= RD + 1);
            ec = !(c <= RD + 2);
            eb = (c <= RD + 2);
            checks++;
            if ({bus.gnt, bus.done, sram_oe_n, sram_cs_n, bus.busy} !== {eg, ed, eo, ec, eb}) begin
                errors++;
                $display("FAIL read_cadence c=%0d gnt=%b done=%b oe_n=%b cs_n=%b busy=%b, expected %b %b %b %b %b",
                         c, bus.gnt, bus.done, sram_oe_n, sram_cs_n, bus.busy, eg, ed, eo, ec, eb);
            end
            if (c == 1) begin
                checks++;
                if (sram_addr !== 17'h00123) begin
                    errors++;
                    $display("FAIL read_addr got=%h expected=00123", sram_addr);
                end
            end
            if (c >= RD + 2) begin
                checks++;
                if (bus.rdata !== 8'hA5) begin
                    errors++;
                    $display("FAIL read_rdata c=%0d got=%h expected=a5", c, bus.rdata);
                end
            end
        end
    endtask

    task automatic test_write;
        logic [N-1:0] eg, ed;
        logic ew, eden;
        int nlow = 0;
        do_reset();
        mem[17'h1FFFF] = 8'h00;
        bus.req_we[0] = 1'b1;
        bus.req_addr[0 +: AW] = 17'h1FFFF;
        bus.req_wdata[0 +: DW] = 8'h3C;
        bus.req[0] = 1'b1;
        for (int c = 1; c <= WR + 4; c++) begin
            tick();
            if (c == 1) begin
                bus.req[0] = 1'b0;
                bus.req_addr[0 +: AW] = 17'h00000;
                bus.req_wdata[0 +: DW] = 8'hFF;
            end
            if (!sram_we_n) nlow++;
            eg = (c == 1) ? N'(1) : '0;
            ed = (c == WR + 2) ? N'(1) : '0;
            ew = !(c >= 2 && c <= WR + 1);
            eden = (c <= WR + 2);
            checks++;
            if ({bus.gnt, bus.done, sram_we_n, sram_den, sram_oe_n} !== {eg, ed, ew, eden, 1'b1}) begin
                errors++;
                $display("FAIL write_cadence c=%0d gnt=%b done=%b we_n=%b den=%b oe_n=%b, expected %b %b %b %b 1",
                         c, bus.gnt, bus.done, sram_we_n, sram_den, sram_oe_n, eg, ed, ew, eden);
            end
            if (eden) begin
                checks++;
                if (sram_dout !== 8'h3C || sram_addr !== 17'h1FFFF) begin
                    errors++;
                    $display("FAIL write_bus_hold c=%0d data=%h addr=%h, expected 3c 1ffff", c, sram_dout, sram_addr);
                end
            end
        end
        checks++;
        if (nlow !== WR) begin
            errors++;
            $display("FAIL write_pulse_len got=%0d expected=%0d", nlow, WR);
        end
        checks++;
        if (mem[17'h1FFFF] !== 8'h3C || bus.rdata !== 8'h00) begin
            errors++;
            $display("FAIL write_result mem=%h rdata=%h, expected 3c 00", mem[17'h1FFFF], bus.rdata);
        end
    endtask

    task automatic test_contention;
        int w, at, prev, ew;
        do_reset();
        bus.req_we = '0;
        for (int k = 0; k < N; k++) bus.req_addr[k*AW +: AW] = AW'(17'h300 + k);
        bus.req = '1;
        prev = -1;
        for (int g = 0; g < 4; g++) begin
            ew = model_pick(bus.req);
            wait_gnt(w, at);
            checks++;
            if (w !== ew) begin
                errors++;
                $display("FAIL contention_order grant#%0d got=%0d expected=%0d", g, w, ew);
            end
            if (w >= 0) rr_ptr = (w + 1) % N;
            if (prev >= 0) begin
                checks++;
                if (at - prev !== P) begin
                    errors++;
                    $display("FAIL contention_period got=%0d expected=%0d", at - prev, P);
                end
            end
            prev = at;
        end
        bus.req = '0;
        for (int i = 0; i < 12 && bus.busy; i++) tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_drain busy=%b expected=0", bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        mem[17'h0ABCD] = 8'h11;
        bus.req_we[2] = 1'b1;
        bus.req_addr[2*AW +: AW] = 17'h0ABCD;
        bus.req_wdata[2*DW +: DW] = 8'h77;
        bus.req[2] = 1'b1;
        tick();
        bus.req[2] = 1'b0;
        tick();
        checks++;
        if (sram_we_n !== 1'b0 || sram_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_access we_n=%b cs_n=%b, expected 0 0", sram_we_n, sram_cs_n);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({sram_cs_n, sram_we_n, sram_den, bus.done, bus.busy} !== {1'b1, 1'b1, 1'b0, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_strobes cs_n=%b we_n=%b den=%b done=%b busy=%b, expected 1 1 0 000 0",
                     sram_cs_n, sram_we_n, sram_den, bus.done, bus.busy);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.done !== '0 || sram_cs_n !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_no_done c=%0d done=%b cs_n=%b, expected 000 1", c, bus.done, sram_cs_n);
            end
        end
        checks++;
        if (mem[17'h0ABCD] !== 8'h11) begin
            errors++;
            $display("FAIL rstmid_mem got=%h expected=11", mem[17'h0ABCD]);
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] eg, ed;
        logic ec;
        logic [DW-1:0] er;
        int s2 = 1 + P;
        do_reset();
        mem[17'h00777] = 8'h5A;
        mem[17'h00042] = 8'hC3;
        bus.req_we = '0;
        bus.req_addr[2*AW +: AW] = 17'h00777;
        bus.req_addr[0 +: AW] = 17'h00042;
        bus.req[2] = 1'b1;
        for (int c = 1; c <= s2 + RD + 3; c++) begin
            tick();
            if (c == 1) begin
                bus.req[2] = 1'b0;
                bus.req[0] = 1'b1;
            end
            if (c == s2) bus.req[0] = 1'b0;
            eg = (c == 1) ? N'(4) : (c == s2) ? N'(1) : '0;
            ed = (c == RD + 2) ? N'(4) : (c == s2 + RD + 1) ? N'(1) : '0;
            ec = (c == RD + 3) || (c >= s2 + RD + 2);
            er = (c < RD + 2) ? 8'h00 : (c < s2 + RD + 1) ? 8'h5A : 8'hC3;
            checks++;
            if ({bus.gnt, bus.done, sram_cs_n, bus.rdata} !== {eg, ed, ec, er}) begin
                errors++;
                $display("FAIL b2b c=%0d gnt=%b done=%b cs_n=%b rdata=%h, expected %b %b %b %h",
                         c, bus.gnt, bus.done, sram_cs_n, bus.rdata, eg, ed, ec, er);
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] pend, add, exp_oh;
        logic [AW-1:0] ta;
        logic [DW-1:0] td, erd;
        logic twe;
        int w, at, ew, dc, prev_done;
        do_reset();
        pend = '0;
        prev_done = -1;
        erd = 8'h00;
        for (int r = 0; r < 30; r++) begin
            add = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) begin
                if (add[k] && !pend[k]) begin
                    bus.req_we[k] = 1'($urandom_range(0, 1));
                    bus.req_addr[k*AW +: AW] = AW'(17'h200 + $urandom_range(0, 15));
                    bus.req_wdata[k*DW +: DW] = DW'($urandom);
                end
            end
            pend = pend | add;
            bus.req = pend;
            ew = model_pick(pend);
            twe = bus.req_we[ew];
            ta = bus.req_addr[ew*AW +: AW];
            td = bus.req_wdata[ew*DW +: DW];
            wait_gnt(w, at);
            checks++;
            if (w !== ew) begin
                errors++;
                $display("FAIL rand_winner round=%0d got=%0d expected=%0d", r, w, ew);
            end
            if (w < 0) break;
            exp_oh = N'(1) << w;
            checks++;
            if (bus.gnt !== exp_oh) begin
                errors++;
                $display("FAIL rand_gnt_onehot round=%0d got=%b expected=%b", r, bus.gnt, exp_oh);
            end
            if (prev_done >= 0) begin
                checks++;
                if (at - prev_done !== 2) begin
                    errors++;
                    $display("FAIL rand_turnaround round=%0d got=%0d expected=2", r, at - prev_done);
                end
            end
            rr_ptr = (w + 1) % N;
            pend[w] = 1'b0;
            bus.req = pend;
            bus.req_addr[w*AW +: AW] = AW'($urandom);
            bus.req_wdata[w*DW +: DW] = DW'($urandom);
            dc = -1;
            for (int i = 0; i < 12 && dc < 0; i++) begin
                tick();
                if (bus.done != '0) dc = cyc;
            end
            if (!twe) erd = ref_rd(int'(ta));
            else ref_mem[int'(ta)] = td;
            checks++;
            if (bus.done !== exp_oh || dc - at !== (twe ? WR : RD) + 1 || bus.rdata !== erd) begin
                errors++;
                $display("FAIL rand_done round=%0d we=%b done=%b lat=%0d rdata=%h, expected done=%b lat=%0d rdata=%h",
                         r, twe, bus.done, dc - at, bus.rdata, exp_oh, (twe ? WR : RD) + 1, erd);
            end
            prev_done = dc;
        end
        bus.req = '0;
        for (int i = 0; i < 12 && bus.busy; i++) tick();
        for (int a = 17'h200; a < 17'h210; a++) begin
            checks++;
            if (mem[a] !== ref_rd(a)) begin
                errors++;
                $display("FAIL rand_mem addr=%h got=%h expected=%h", a, mem[a], ref_rd(a));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        bus.req = '0;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d, expected bench to finish", cyc);
        $fatal(1);
    end

endmodule
